// File: rtl/riscv_axi_pkg.sv
// Shared AXI4-Lite definitions for the CPU-side bus master: response codes,
// FSM state encoding and a response classification helper.
package riscv_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE,
        WRESP = ST_WRESP,
        READ  = ST_READ,
        RDATA = ST_RDATA
    } axi_state_e;

    // Anything other than OKAY (including EXOKAY, meaningless on AXI-Lite) is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY:                                   resp_is_err = 1'b0;
            AXI_RESP_EXOKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR: resp_is_err = 1'b1;
            default:                                         resp_is_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one CPU valid/ready request into an
// AXI-Lite read or write and returns a one-cycle response pulse with data and error flag.
module riscv_axi_lite_master
    import riscv_axi_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                  riscv_cpu_clk,
    input  logic                  riscv_cpu_reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    axi_state_e            state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_W-1:0]     araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (req_we) begin
                        state_d   = WRITE;
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W complete independently; the sticky bits remember which is done.
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (m_axi_bvalid && bready_q) begin
                    state_d      = IDLE;
                    bready_d     = 1'b0;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = resp_is_err(m_axi_bresp);
                end
            end
            READ: begin
                if (m_axi_arready) begin
                    state_d   = RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RDATA: begin
                if (m_axi_rvalid && rready_q) begin
                    state_d      = IDLE;
                    rready_d     = 1'b0;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = m_axi_rdata;
                    resp_err_d   = resp_is_err(m_axi_rresp);
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge riscv_cpu_clk or negedge riscv_cpu_reset_n) begin
        if (!riscv_cpu_reset_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
